exe_issue_ctrl: RTL and testbench

//  Execute-stage controller between decode and the ALU: buffers decoded uops and

---
 rtl/exe_ctrl_pkg.sv | 42 ++++
 rtl/exe_issue_ctrl_uop_fifo.sv | 71 +++++++
 rtl/exe_issue_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_exe_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_ctrl_pkg.sv
// Shared types for the execute-stage issue controller: FSM states, opcode
// classes, the buffered uop record and the opcode classifier.
package exe_ctrl_pkg;

    typedef logic [9:0] opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_MULTI,
        ST_BR_WAIT,
        ST_FLUSH
    } exe_state_t;

    typedef enum logic [1:0] {
        OP_SINGLE,
        OP_MULTI,
        OP_BR
    } op_class_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [63:0] oprd1;
        logic [63:0] oprd2;
        logic [63:0] oprd3;
        logic [63:0] next_rip;
    } uop_entry_t;

    // IMUL/SHL hold the ALU for several cycles; jumps and Jcc are serialised.
    function automatic op_class_t op_class(input opcode_t op);
        op_class_t cls;
        cls = OP_SINGLE;
        if (op == 10'h0F7 || op == 10'h305) begin
            cls = OP_MULTI;
        end else if ((op >= 10'h070 && op <= 10'h07F) || op == 10'h0E9 ||
                     op == 10'h0EB || (op >= 10'h180 && op <= 10'h18F)) begin
            cls = OP_BR;
        end
        return cls;
    endfunction

endpackage

// File: rtl/exe_issue_ctrl_uop_fifo.sv
// uop_fifo: DEPTH-entry uop buffer with synchronous flush. Exposes the head
// and the entry behind it so the controller can issue back-to-back.
module uop_fifo
    import exe_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  uop_entry_t                   push_data,
    input  logic                         pop,
    input  logic                         flush,
    output uop_entry_t                   head,
    output uop_entry_t                   head_next,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    uop_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update; flush discards contents and any same-cycle push.
    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count     = count_q;

endmodule

// File: rtl/exe_issue_ctrl.sv
// exe_issue_ctrl: issues buffered uops to the ALU one at a time, holds
// multi-cycle ops, serialises branches and turns a taken branch into a
// flush/redirect. Optional perf counters under EXE_CTRL_PERF_EN.
module exe_issue_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_opcode,
    input  logic [63:0] in_oprd1,
    input  logic [63:0] in_oprd2,
    input  logic [63:0] in_oprd3,
    input  logic [63:0] in_next_rip,
    output logic        alu_enable,
    output logic [9:0]  alu_opcode,
    output logic [63:0] alu_oprd1,
    output logic [63:0] alu_oprd2,
    output logic [63:0] alu_oprd3,
    output logic [63:0] alu_next_rip,
    input  logic        mem_blocked,
    input  logic        alu_branch,
    input  logic [63:0] alu_branch_rip,
    output logic        flush,
    output logic [63:0] redirect_rip,
    output logic        busy
`ifdef EXE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_flush
`endif
);
    localparam int LAT_W = $clog2(MUL_LAT + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    exe_state_t       state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             alu_enable_q, alu_enable_d;
    uop_entry_t       alu_uop_q, alu_uop_d;
    logic             flush_q, flush_d;
    logic [63:0]      redirect_rip_q, redirect_rip_d;

    uop_entry_t       fifo_head, fifo_next, in_uop;
    logic [CNT_W-1:0] count;
    logic             fifo_push, fifo_pop, fifo_flush;
    logic             head_valid, next_valid, load_head, advance;

    assign in_uop     = '{opcode: in_opcode, oprd1: in_oprd1, oprd2: in_oprd2,
                          oprd3: in_oprd3, next_rip: in_next_rip};
    assign in_ready   = (count != CNT_W'(DEPTH)) && (state_q != ST_FLUSH);
    assign fifo_push  = in_valid && in_ready;
    assign fifo_flush = (state_q == ST_FLUSH);
    assign head_valid = (count != '0);
    assign next_valid = (count >= CNT_W'(2));

    uop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (in_uop),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .head_next (fifo_next),
        .count     (count)
    );

    // Next-state, pop decision and issue register loading.
    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        alu_enable_d   = alu_enable_q;
        alu_uop_d      = alu_uop_q;
        flush_d        = 1'b0;
        redirect_rip_d = '0;
        fifo_pop       = 1'b0;
        load_head      = 1'b0;
        advance        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                alu_enable_d = 1'b0;
                load_head    = head_valid && !mem_blocked;
            end
            ST_ISSUE: begin
                if (!mem_blocked) begin
                    if (op_class(alu_uop_q.opcode) == OP_MULTI && MUL_LAT > 1) begin
                        state_d   = ST_MULTI;
                        lat_cnt_d = LAT_W'(MUL_LAT - 1);
                    end else if (op_class(alu_uop_q.opcode) == OP_BR) begin
                        fifo_pop     = 1'b1;
                        state_d      = ST_BR_WAIT;
                        alu_enable_d = 1'b0;
                    end else begin
                        fifo_pop = 1'b1;
                        advance  = 1'b1;
                    end
                end
            end
            ST_MULTI: begin
                if (!mem_blocked) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(1)) begin
                        fifo_pop = 1'b1;
                        advance  = 1'b1;
                    end
                end
            end
            ST_BR_WAIT: begin
                // The ALU's branch verdict is sampled here even under a memory stall.
                if (alu_branch) begin
                    state_d        = ST_FLUSH;
                    flush_d        = 1'b1;
                    redirect_rip_d = alu_branch_rip;
                end else begin
                    state_d   = ST_IDLE;
                    load_head = head_valid && !mem_blocked;
                end
            end
            ST_FLUSH: begin
                state_d      = ST_IDLE;
                alu_enable_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                alu_enable_d = 1'b0;
            end
        endcase
        if (advance) begin
            if (next_valid) begin
                state_d      = ST_ISSUE;
                alu_enable_d = 1'b1;
                alu_uop_d    = fifo_next;
            end else begin
                state_d      = ST_IDLE;
                alu_enable_d = 1'b0;
            end
        end
        if (load_head) begin
            state_d      = ST_ISSUE;
            alu_enable_d = 1'b1;
            alu_uop_d    = fifo_head;
        end
    end

    // FSM, latency counter and registered ALU/flush outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            lat_cnt_q      <= '0;
            alu_enable_q   <= 1'b0;
            alu_uop_q      <= '0;
            flush_q        <= 1'b0;
            redirect_rip_q <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            alu_enable_q   <= alu_enable_d;
            alu_uop_q      <= alu_uop_d;
            flush_q        <= flush_d;
            redirect_rip_q <= redirect_rip_d;
        end
    end

    assign alu_enable   = alu_enable_q;
    assign alu_opcode   = alu_uop_q.opcode;
    assign alu_oprd1    = alu_uop_q.oprd1;
    assign alu_oprd2    = alu_uop_q.oprd2;
    assign alu_oprd3    = alu_uop_q.oprd3;
    assign alu_next_rip = alu_uop_q.next_rip;
    assign flush        = flush_q;
    assign redirect_rip = redirect_rip_q;
    assign busy         = head_valid || (state_q != ST_IDLE);

`ifdef EXE_CTRL_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        if (fifo_pop && head_valid && perf_issued_q != '1) perf_issued_d = perf_issued_q + 32'd1;
        if (mem_blocked && busy && perf_stall_q != '1)     perf_stall_d  = perf_stall_q + 32'd1;
        if (flush_q && perf_flush_q != '1)                 perf_flush_d  = perf_flush_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Testbench for exe_issue_ctrl: directed scenarios followed by random traffic,
// checked by a queue-based reference model in a separate monitor process.
module tb_exe_issue_ctrl;

    localparam int DEPTH   = 2;
    localparam int MUL_LAT = 3;

    typedef struct {
        logic [9:0]  op;
        logic [63:0] a, b, c, rip;
        int          acc;
    } ent_t;

    logic        clk, reset_n;
    logic        in_valid, in_ready;
    logic [9:0]  in_opcode;
    logic [63:0] in_oprd1, in_oprd2, in_oprd3, in_next_rip;
    logic        alu_enable;
    logic [9:0]  alu_opcode;
    logic [63:0] alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip;
    logic        mem_blocked, alu_branch;
    logic [63:0] alu_branch_rip;
    logic        flush;
    logic [63:0] redirect_rip;
    logic        busy;
`ifdef EXE_CTRL_PERF_EN
    logic [31:0] perf_issued, perf_stall;
    logic [15:0] perf_flush;
`endif

    exe_issue_ctrl #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_oprd1       (in_oprd1),
        .in_oprd2       (in_oprd2),
        .in_oprd3       (in_oprd3),
        .in_next_rip    (in_next_rip),
        .alu_enable     (alu_enable),
        .alu_opcode     (alu_opcode),
        .alu_oprd1      (alu_oprd1),
        .alu_oprd2      (alu_oprd2),
        .alu_oprd3      (alu_oprd3),
        .alu_next_rip   (alu_next_rip),
        .mem_blocked    (mem_blocked),
        .alu_branch     (alu_branch),
        .alu_branch_rip (alu_branch_rip),
        .flush          (flush),
        .redirect_rip   (redirect_rip),
        .busy           (busy)
`ifdef EXE_CTRL_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ent_t q[$];
    int   tk_mode = -1;
    logic [63:0] tk_rip = '0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endfunction

    function automatic bit is_br(input logic [9:0] op);
        return (op >= 10'h070 && op <= 10'h07F) || op == 10'h0E9 || op == 10'h0EB ||
               (op >= 10'h180 && op <= 10'h18F);
    endfunction

    function automatic int need_cycles(input logic [9:0] op);
        return (op == 10'h0F7 || op == 10'h305) ? MUL_LAT : 1;
    endfunction

    function automatic ent_t mk(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [63:0] rip);
        ent_t e;
        e.op = op; e.a = a; e.b = b; e.c = c; e.rip = rip; e.acc = 0;
        return e;
    endfunction

    // One clock of stimulus; an accepted uop is queued as an expected issue.
    task automatic drive(input bit v, input ent_t e, input bit mb);
        ent_t ee;
        @(posedge clk); #1;
        in_valid    = v;
        in_opcode   = e.op;
        in_oprd1    = e.a;
        in_oprd2    = e.b;
        in_oprd3    = e.c;
        in_next_rip = e.rip;
        mem_blocked = mb;
        @(negedge clk);
        if (in_valid && in_ready && reset_n) begin
            ee     = e;
            ee.acc = cyc;
            q.push_back(ee);
        end
    endtask

    task automatic idle(input int n, input bit mb);
        for (int i = 0; i < n; i++) drive(1'b0, mk(10'h000, 0, 0, 0, 0), mb);
    endtask

    // Reference model and monitor: one evaluation per cycle, 2 time units after the edge.
    initial begin : monitor
        bit act, brw, tk, fl, rst_prev, mb, start;
        int done, occ;
        logic [63:0] brip, frip;
        ent_t popped;
        act = 0; brw = 0; tk = 0; fl = 0; rst_prev = 0; done = 0; brip = '0; frip = '0;
        alu_branch = 1'b0;
        alu_branch_rip = '0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            mb = mem_blocked;
            alu_branch     = brw && tk;
            alu_branch_rip = (brw && tk) ? brip : 64'h0;

            occ = 0;
            foreach (q[i]) if (q[i].acc < cyc) occ++;

            chk("alu_enable", 64'(alu_enable), 64'(act));
            if (act) begin
                chk("alu_opcode", 64'(alu_opcode), 64'(q[0].op));
                chk("alu_oprd1", alu_oprd1, q[0].a);
                chk("alu_oprd2", alu_oprd2, q[0].b);
                chk("alu_oprd3", alu_oprd3, q[0].c);
                chk("alu_next_rip", alu_next_rip, q[0].rip);
            end
            chk("flush", 64'(flush), 64'(fl));
            if (fl) chk("redirect_rip", redirect_rip, frip);
            chk("in_ready", 64'(in_ready), 64'((occ < DEPTH) && !fl));
            chk("busy", 64'(busy), 64'((occ > 0) || act || brw || fl));
            if (rst_prev) begin
                chk("rst_alu_opcode", 64'(alu_opcode), 64'h0);
                chk("rst_alu_oprd1", alu_oprd1, 64'h0);
                chk("rst_redirect", redirect_rip, 64'h0);
            end

            start = 0;
            if (fl) begin
                q.delete();
                fl = 0;
                start = 1;
            end else if (brw) begin
                brw = 0;
                if (tk) begin
                    fl   = 1;
                    frip = brip;
                end else begin
                    start = 1;
                end
            end else if (act) begin
                if (!mb) done++;
                if (done >= need_cycles(q[0].op)) begin
                    popped = q.pop_front();
                    act    = 0;
                    if (is_br(popped.op)) begin
                        brw  = 1;
                        tk   = (tk_mode < 0) ? 1'($urandom_range(0, 1)) : tk_mode[0];
                        brip = (tk_mode < 0) ? {$urandom, $urandom} : tk_rip;
                    end else begin
                        start = 1;
                    end
                end
            end else begin
                start = 1;
            end
            if (start && q.size() > 0 && q[0].acc < cyc && !mb) begin
                act  = 1;
                done = 0;
            end

            if (!reset_n) begin
                q.delete();
                act = 0; brw = 0; fl = 0; tk = 0; done = 0;
            end
            rst_prev = !reset_n;
        end
    end

    logic [9:0] ops [12];

    initial begin : stimulus
        ent_t nop;
        ops = '{10'h001, 10'h008, 10'h0F7, 10'h305, 10'h184, 10'h0E9,
                10'h304, 10'h070, 10'h07F, 10'h0EB, 10'h18F, 10'h010};
        nop = mk(10'h000, 0, 0, 0, 0);
        reset_n = 1'b0; in_valid = 1'b0; mem_blocked = 1'b0;
        in_opcode = '0; in_oprd1 = '0; in_oprd2 = '0; in_oprd3 = '0; in_next_rip = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2, 1'b0);

        // Single-cycle ADD
        drive(1'b1, mk(10'h001, 64'd5, 64'd7, 64'd0, 64'h1004), 1'b0);
        idle(4, 1'b0);

        // IMUL held for MUL_LAT cycles, then OR
        drive(1'b1, mk(10'h0F7, 64'd3, 64'd9, 64'd1, 64'h1008), 1'b0);
        drive(1'b1, mk(10'h008, 64'hF0, 64'h0F, 64'd0, 64'h100C), 1'b0);
        idle(7, 1'b0);

        // Fill while memory stalled, then release
        drive(1'b1, mk(10'h001, 64'd1, 64'd2, 64'd0, 64'h2000), 1'b1);
        drive(1'b1, mk(10'h304, 64'd8, 64'd3, 64'd0, 64'h2004), 1'b1);
        drive(1'b1, mk(10'h008, 64'd4, 64'd4, 64'd0, 64'h2008), 1'b1);
        idle(3, 1'b1);
        idle(5, 1'b0);

        // Taken Jcc flushes the buffered SUB
        tk_mode = 1; tk_rip = 64'h4000;
        drive(1'b1, mk(10'h184, 64'd0, 64'd0, 64'd0, 64'h3004), 1'b0);
        drive(1'b1, mk(10'h304, 64'd9, 64'd1, 64'd0, 64'h3008), 1'b0);
        idle(6, 1'b0);

        // Not-taken JMP, next uop issues right after BR_WAIT
        tk_mode = 0;
        drive(1'b1, mk(10'h0E9, 64'd0, 64'd0, 64'd0, 64'h5004), 1'b0);
        drive(1'b1, mk(10'h001, 64'd11, 64'd22, 64'd0, 64'h5008), 1'b0);
        idle(6, 1'b0);
        tk_mode = -1;

        // Reset in the middle of a multi-cycle op
        drive(1'b1, mk(10'h305, 64'd6, 64'd2, 64'd0, 64'h6004), 1'b0);
        idle(2, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(3, 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 9) < 6),
                  mk(ops[$urandom_range(0, 11)], {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom}),
                  1'($urandom_range(0, 4) == 0));
        end
        idle(20, 1'b0);
        chk("drain_queue", 64'(q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
